id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold control and load-use hazard bubbling.
// Hazard detection and bubble counter exist only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [DW-1:0] i_pc,
  input  logic [DW-1:0] i_rs1_data,
  input  logic [DW-1:0] i_rs2_data,
  input  logic [DW-1:0] i_imm,
  input  logic [31:0]   i_instr,
  input  logic [14:0]   i_ctrl_word,
  input  logic          i_flush,
  input  logic          i_hold,
  output logic [DW-1:0] o_pc,
  output logic [DW-1:0] o_rs1_data,
  output logic [DW-1:0] o_rs2_data,
  output logic [DW-1:0] o_imm,
  output logic [4:0]    o_rd,
  output logic [4:0]    o_rs1,
  output logic [4:0]    o_rs2,
  output logic [14:0]   o_ctrl_word,
  output logic          o_valid,
  output logic          o_stall_id,
  output logic [15:0]   o_bubble_cnt
);

  localparam int unsigned INSN_VLD_BIT = 14;
  localparam int unsigned MEM_RDEN_BIT = 2;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       hazard;
  logic       bubble;

  assign id_rs1 = i_instr[19:15];
  assign id_rs2 = i_instr[24:20];
  assign id_rd  = i_instr[11:7];

`ifdef ID_EX_HAZARD_DETECT_EN
  logic [6:0]  opcode;
  logic        rs1_used;
  logic        rs2_used;
  logic [15:0] bubble_cnt;
  logic        unused_instr;

  assign opcode       = i_instr[6:0];
  assign unused_instr = ^{i_instr[31:25], i_instr[14:12]};

  // Only a load already in EX can create a hazard; x0 is never a real dependency.
  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: rs1_used = 1'b0;
      default: ;
    endcase
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: rs2_used = 1'b1;
      default: ;
    endcase
    hazard = o_valid & o_ctrl_word[MEM_RDEN_BIT] & (o_rd != 5'd0) &
             (((o_rd == id_rs1) & rs1_used) | ((o_rd == id_rs2) & rs2_used));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bubble_cnt <= '0;
    end else if (o_stall_id && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt;
`else
  logic unused_instr;

  assign unused_instr = ^{i_instr[31:25], i_instr[14:12], i_instr[6:0]};
  assign hazard       = 1'b0;
  assign o_bubble_cnt = '0;
`endif

  // A flush outranks hold; a hazard bubble only happens when neither is active.
  assign o_stall_id = hazard & ~i_flush & ~i_hold;
  assign bubble     = i_flush | o_stall_id;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_pc        <= '0;
      o_rs1_data  <= '0;
      o_rs2_data  <= '0;
      o_imm       <= '0;
      o_rd        <= '0;
      o_rs1       <= '0;
      o_rs2       <= '0;
      o_ctrl_word <= '0;
      o_valid     <= 1'b0;
    end else if (bubble) begin
      o_pc        <= '0;
      o_rs1_data  <= '0;
      o_rs2_data  <= '0;
      o_imm       <= '0;
      o_rd        <= '0;
      o_rs1       <= '0;
      o_rs2       <= '0;
      o_ctrl_word <= '0;
      o_valid     <= 1'b0;
    end else if (!i_hold) begin
      o_pc        <= i_pc;
      o_rs1_data  <= i_rs1_data;
      o_rs2_data  <= i_rs2_data;
      o_imm       <= i_imm;
      o_rd        <= id_rd;
      o_rs1       <= id_rs1;
      o_rs2       <= id_rs2;
      o_ctrl_word <= i_ctrl_word;
      o_valid     <= i_ctrl_word[INSN_VLD_BIT];
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; hazard expectations follow
// whether ID_EX_HAZARD_DETECT_EN is defined for the build.
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  localparam logic [14:0] C_LW   = 15'h4486;
  localparam logic [14:0] C_ADDI = 15'h4402;
  localparam logic [14:0] C_ADD  = 15'h4002;
  localparam logic [14:0] C_LUI  = 15'h4C02;
  localparam logic [14:0] C_SW   = 15'h4401;

  localparam logic [31:0] I_ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] I_LW_X5       = 32'h0000A283;
  localparam logic [31:0] I_LW_X0       = 32'h0000A003;
  localparam logic [31:0] I_ADD_X6_X5X7 = 32'h00728333;
  localparam logic [31:0] I_ADD_X6_X0X0 = 32'h00000333;
  localparam logic [31:0] I_LUI_X5      = 32'h000282B7;
  localparam logic [31:0] I_SW_X5       = 32'h00512023;
  localparam logic [31:0] I_ADDI_X7_X1  = 32'h00508393;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_pc = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0, i_instr = '0;
  logic [14:0] i_ctrl_word = '0;
  logic        i_flush = 1'b0, i_hold = 1'b0;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [14:0] o_ctrl_word;
  logic        o_valid, o_stall_id;
  logic [15:0] o_bubble_cnt;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = '0;

  id_ex_stage #(.DW(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc(i_pc), .i_rs1_data(i_rs1_data),
    .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_instr(i_instr), .i_ctrl_word(i_ctrl_word),
    .i_flush(i_flush), .i_hold(i_hold), .o_pc(o_pc), .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_ctrl_word(o_ctrl_word), .o_valid(o_valid), .o_stall_id(o_stall_id),
    .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [14:0] ctrl);
    i_pc = pc; i_instr = instr; i_rs1_data = r1; i_rs2_data = r2; i_imm = imm; i_ctrl_word = ctrl;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    drive(32'h44, I_ADDI_X1_5, 32'h1, 32'h2, 32'h5, C_ADDI);
    step(); step();
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", o_pc); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_ctrl_word !== 15'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", o_ctrl_word); end
    total++; if (o_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", o_rd); end
    total++; if (o_imm !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h want=0", o_imm); end
    total++; if (o_bubble_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", o_bubble_cnt); end
    i_reset = 1'b1;
  endtask

  task automatic test_plain();
    drive(32'h0, I_ADDI_X1_5, 32'h0, 32'h0, 32'h5, C_ADDI);
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL plain_stall got=%b want=0", o_stall_id); end
    step();
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL plain_pc got=%h want=0", o_pc); end
    total++; if (o_rd !== 5'd1) begin bad++; $display("FAIL plain_rd got=%0d want=1", o_rd); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%b want=1", o_valid); end
    total++; if (o_imm !== 32'h5) begin bad++; $display("FAIL plain_imm got=%h want=5", o_imm); end
    total++; if (o_ctrl_word !== C_ADDI) begin bad++; $display("FAIL plain_ctrl got=%h want=%h", o_ctrl_word, C_ADDI); end
    total++; if (o_rs2 !== 5'd5) begin bad++; $display("FAIL plain_rs2 got=%0d want=5", o_rs2); end
    drive(32'h40, I_ADD_X6_X5X7, 32'hAAAA5555, 32'h12345678, 32'h0, C_ADD);
    step();
    total++; if (o_pc !== 32'h40) begin bad++; $display("FAIL lat_pc got=%h want=40", o_pc); end
    total++; if (o_rs1_data !== 32'hAAAA5555) begin bad++; $display("FAIL lat_rs1d got=%h want=aaaa5555", o_rs1_data); end
    total++; if (o_rs2_data !== 32'h12345678) begin bad++; $display("FAIL lat_rs2d got=%h want=12345678", o_rs2_data); end
    total++; if ({o_rd, o_rs1, o_rs2} !== {5'd6, 5'd5, 5'd7}) begin bad++; $display("FAIL lat_regs got=%0d/%0d/%0d want=6/5/7", o_rd, o_rs1, o_rs2); end
    drive(32'h44, I_ADDI_X1_5, 32'h0, 32'h0, 32'h5, 15'h0402);
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL invalid_valid got=%b want=0", o_valid); end
    total++; if (o_ctrl_word !== 15'h0402) begin bad++; $display("FAIL invalid_ctrl got=%h want=0402", o_ctrl_word); end
    total++; if (o_pc !== 32'h44) begin bad++; $display("FAIL invalid_pc got=%h want=44", o_pc); end
  endtask

  task automatic test_load_use();
    drive(32'h8, I_LW_X5, 32'h100, 32'h0, 32'h0, C_LW);
    step();
    total++; if (o_rd !== 5'd5 || o_valid !== 1'b1) begin bad++; $display("FAIL lu_load got=rd%0d/v%b want=rd5/v1", o_rd, o_valid); end
    drive(32'hC, I_ADD_X6_X5X7, 32'h0, 32'h0, 32'h0, C_ADD);
    #1;
    total++; if (o_stall_id !== HZ) begin bad++; $display("FAIL lu_stall got=%b want=%b", o_stall_id, HZ); end
    step();
    exp_cnt += 16'(HZ);
    total++; if (o_valid !== !HZ) begin bad++; $display("FAIL lu_bubble_valid got=%b want=%b", o_valid, !HZ); end
    total++; if (o_ctrl_word !== (HZ ? 15'h0 : C_ADD)) begin bad++; $display("FAIL lu_bubble_ctrl got=%h", o_ctrl_word); end
    total++; if (o_pc !== (HZ ? 32'h0 : 32'hC)) begin bad++; $display("FAIL lu_bubble_pc got=%h", o_pc); end
    total++; if (o_bubble_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt got=%0d want=%0d", o_bubble_cnt, exp_cnt); end
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b want=0", o_stall_id); end
    step();
    total++; if (o_rd !== 5'd6 || o_valid !== 1'b1 || o_pc !== 32'hC) begin bad++; $display("FAIL lu_reload got=rd%0d/v%b/pc%h want=rd6/v1/pcC", o_rd, o_valid, o_pc); end
    drive(32'h10, I_LW_X5, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h14, I_SW_X5, 32'h0, 32'h0, 32'h0, C_SW);
    #1;
    total++; if (o_stall_id !== HZ) begin bad++; $display("FAIL rs2_stall got=%b want=%b", o_stall_id, HZ); end
    step();
    exp_cnt += 16'(HZ);
    total++; if (o_valid !== !HZ) begin bad++; $display("FAIL rs2_bubble got=%b want=%b", o_valid, !HZ); end
    total++; if (o_bubble_cnt !== exp_cnt) begin bad++; $display("FAIL rs2_cnt got=%0d want=%0d", o_bubble_cnt, exp_cnt); end
    step();
    total++; if (o_ctrl_word !== C_SW) begin bad++; $display("FAIL rs2_reload got=%h want=%h", o_ctrl_word, C_SW); end
  endtask

  task automatic test_false_hazard();
    drive(32'h20, I_LW_X0, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h24, I_ADD_X6_X0X0, 32'h0, 32'h0, 32'h0, C_ADD);
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL fh_x0 got=%b want=0", o_stall_id); end
    step();
    total++; if (o_rd !== 5'd6 || o_valid !== 1'b1) begin bad++; $display("FAIL fh_x0_load got=rd%0d/v%b", o_rd, o_valid); end
    drive(32'h28, I_LW_X5, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h2C, I_LUI_X5, 32'h0, 32'h0, 32'h28000, C_LUI);
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL fh_lui got=%b want=0", o_stall_id); end
    step();
    total++; if (o_ctrl_word !== C_LUI || o_imm !== 32'h28000) begin bad++; $display("FAIL fh_lui_load got=%h/%h", o_ctrl_word, o_imm); end
    drive(32'h30, I_LW_X5, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h34, I_ADDI_X7_X1, 32'h0, 32'h0, 32'h5, C_ADDI);
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL fh_itype_rs2 got=%b want=0", o_stall_id); end
    step();
    drive(32'h38, I_LW_X5, 32'h0, 32'h0, 32'h0, 15'h0486);
    step();
    drive(32'h3C, I_ADD_X6_X5X7, 32'h0, 32'h0, 32'h0, C_ADD);
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL fh_invalid_load got=%b want=0", o_stall_id); end
    step();
    total++; if (o_bubble_cnt !== exp_cnt) begin bad++; $display("FAIL fh_cnt got=%0d want=%0d", o_bubble_cnt, exp_cnt); end
  endtask

  task automatic test_flush_vs_hazard();
    drive(32'h50, I_LW_X5, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h54, I_ADD_X6_X5X7, 32'h9, 32'h9, 32'h9, C_ADD);
    i_flush = 1'b1;
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL fvh_stall got=%b want=0", o_stall_id); end
    step();
    total++; if (o_valid !== 1'b0 || o_ctrl_word !== 15'h0 || o_rd !== 5'd0) begin bad++; $display("FAIL fvh_bubble got=v%b/%h/rd%0d", o_valid, o_ctrl_word, o_rd); end
    total++; if (o_pc !== 32'h0 || o_rs1_data !== 32'h0 || o_rs1 !== 5'd0) begin bad++; $display("FAIL fvh_zero got=%h/%h/%0d", o_pc, o_rs1_data, o_rs1); end
    total++; if (o_bubble_cnt !== exp_cnt) begin bad++; $display("FAIL fvh_cnt got=%0d want=%0d", o_bubble_cnt, exp_cnt); end
    i_flush = 1'b0;
    step();
    total++; if (o_rd !== 5'd6 || o_valid !== 1'b1) begin bad++; $display("FAIL fvh_after got=rd%0d/v%b", o_rd, o_valid); end
  endtask

  task automatic test_hold();
    drive(32'h100, I_ADDI_X1_5, 32'h11, 32'h22, 32'h5, C_ADDI);
    step();
    i_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h200 + 32'(k), I_LW_X5, 32'h77 + 32'(k), 32'h88, 32'h99, C_LW);
      step();
      total++; if (o_pc !== 32'h100 || o_rs1_data !== 32'h11 || o_imm !== 32'h5 || o_rd !== 5'd1 || o_ctrl_word !== C_ADDI || o_valid !== 1'b1) begin
        bad++; $display("FAIL hold_%0d got=pc%h/rd%0d/ctrl%h", k, o_pc, o_rd, o_ctrl_word);
      end
    end
    i_hold = 1'b0;
    step();
    drive(32'h204, I_ADD_X6_X5X7, 32'h0, 32'h0, 32'h0, C_ADD);
    i_hold = 1'b1;
    #1;
    total++; if (o_stall_id !== 1'b0) begin bad++; $display("FAIL hold_hz_stall got=%b want=0", o_stall_id); end
    step();
    total++; if (o_rd !== 5'd5 || o_ctrl_word !== C_LW || o_bubble_cnt !== exp_cnt) begin bad++; $display("FAIL hold_hz_keep got=rd%0d/%h/%0d", o_rd, o_ctrl_word, o_bubble_cnt); end
    i_hold = 1'b0;
    #1;
    total++; if (o_stall_id !== HZ) begin bad++; $display("FAIL hold_release_stall got=%b want=%b", o_stall_id, HZ); end
    step();
    exp_cnt += 16'(HZ);
    total++; if (o_valid !== !HZ || o_bubble_cnt !== exp_cnt) begin bad++; $display("FAIL hold_release got=v%b/%0d want=%0d", o_valid, o_bubble_cnt, exp_cnt); end
    step();
  endtask

  task automatic test_async_reset();
    drive(32'h300, I_ADDI_X1_5, 32'h3, 32'h4, 32'h5, C_ADDI);
    step();
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b want=1", o_valid); end
    #2 i_reset = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_ctrl_word !== 15'h0 || o_rd !== 5'd0 || o_imm !== 32'h0) begin
      bad++; $display("FAIL ar_clear got=v%b/pc%h/%h/rd%0d", o_valid, o_pc, o_ctrl_word, o_rd);
    end
    total++; if (o_bubble_cnt !== 16'h0) begin bad++; $display("FAIL ar_cnt got=%0d want=0", o_bubble_cnt); end
    exp_cnt = '0;
    i_reset = 1'b1;
    step();
    total++; if (o_pc !== 32'h300 || o_valid !== 1'b1) begin bad++; $display("FAIL ar_first_edge got=pc%h/v%b", o_pc, o_valid); end
    drive(32'h304, I_LW_X5, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h308, I_ADD_X6_X5X7, 32'h0, 32'h0, 32'h0, C_ADD);
    #1 i_reset = 1'b0;
    #1;
    total++; if (o_stall_id !== 1'b0 || o_valid !== 1'b0) begin bad++; $display("FAIL ar_mid_hazard got=s%b/v%b", o_stall_id, o_valid); end
    i_reset = 1'b1;
    step();
  endtask

`ifdef ID_EX_HAZARD_DETECT_EN
  task automatic test_saturation();
    force dut.bubble_cnt = 16'hFFFF;
    #1;
    release dut.bubble_cnt;
    #1;
    total++; if (o_bubble_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_forced got=%h want=ffff", o_bubble_cnt); end
    drive(32'h400, I_LW_X5, 32'h0, 32'h0, 32'h0, C_LW);
    step();
    drive(32'h404, I_ADD_X6_X5X7, 32'h0, 32'h0, 32'h0, C_ADD);
    #1;
    total++; if (o_stall_id !== 1'b1) begin bad++; $display("FAIL sat_stall got=%b want=1", o_stall_id); end
    step();
    total++; if (o_bubble_cnt !== 16'hFFFF || o_valid !== 1'b0) begin bad++; $display("FAIL sat_hold got=%h/v%b want=ffff/v0", o_bubble_cnt, o_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_plain();
    test_load_use();
    test_false_hazard();
    test_flush_vs_hazard();
    test_hold();
    test_async_reset();
`ifdef ID_EX_HAZARD_DETECT_EN
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
